// File: rtl/alu_rs_pkg.sv
// Shared opcode classes, funct3/diff codes and default sizing
// for the ALU reservation station.
package alu_rs_pkg;

    localparam int DEF_RS_SIZE  = 8;
    localparam int DEF_RS_IDX_W = 3;
    localparam int DEF_TAG_W    = 4;
    localparam int WORD_W       = 32;

    localparam logic [WORD_W-1:0] ZERO_WORD = '0;

    localparam logic [1:0] ALU_CMP    = 2'd1;
    localparam logic [1:0] ALU_ALUOP  = 2'd2;
    localparam logic [1:0] ALU_ALUOPI = 2'd3;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic DIFF_NORM = 1'b0;
    localparam logic DIFF_ALT  = 1'b1;

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index priority encoder: first set bit of req
// and whether any bit is set.
module rs_pick #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds ops until operands are ready,
// snoops the CDB and issues one op per cycle as registered ALU inputs.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE  = DEF_RS_SIZE,
    parameter int RS_IDX_W = DEF_RS_IDX_W,
    parameter int TAG_W    = DEF_TAG_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              disp_valid,
    input  logic [1:0]        disp_type,
    input  logic [2:0]        disp_details,
    input  logic              disp_diff,
    input  logic [31:0]       disp_vj,
    input  logic              disp_qj_busy,
    input  logic [TAG_W-1:0]  disp_qj,
    input  logic [31:0]       disp_vk,
    input  logic              disp_qk_busy,
    input  logic [TAG_W-1:0]  disp_qk,
    input  logic [TAG_W-1:0]  disp_dest,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [31:0]       cdb_value,
    output logic              full,
    output logic              alu_valid,
    output logic [1:0]        alu_type,
    output logic [2:0]        alu_details,
    output logic              alu_diff,
    output logic [31:0]       alu_r1,
    output logic [31:0]       alu_r2,
    output logic [TAG_W-1:0]  alu_tag
);

    typedef struct packed {
        logic             valid;
        logic [1:0]       typ;
        logic [2:0]       details;
        logic             diff;
        logic             qj_busy;
        logic [TAG_W-1:0] qj;
        logic [31:0]      vj;
        logic             qk_busy;
        logic [TAG_W-1:0] qk;
        logic [31:0]      vk;
        logic [TAG_W-1:0] dest;
    } entry_t;

    entry_t rs_q [RS_SIZE];

    logic [RS_SIZE-1:0]  free_vec;
    logic [RS_SIZE-1:0]  ready_vec;
    logic [RS_IDX_W-1:0] free_idx;
    logic [RS_IDX_W-1:0] rdy_idx;
    logic                free_found;
    logic                rdy_found;
    logic                byp_j;
    logic                byp_k;
    entry_t              disp_entry;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i]  = !rs_q[i].valid;
            ready_vec[i] = rs_q[i].valid
                         && !rs_q[i].qj_busy
                         && !rs_q[i].qk_busy;
        end
    end

    rs_pick #(
        .N     (RS_SIZE),
        .IDX_W (RS_IDX_W)
    ) u_free_pick (
        .req   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_pick #(
        .N     (RS_SIZE),
        .IDX_W (RS_IDX_W)
    ) u_ready_pick (
        .req   (ready_vec),
        .idx   (rdy_idx),
        .found (rdy_found)
    );

    assign full = !free_found;

    // A broadcast in the dispatch cycle resolves the operand before storage
    assign byp_j = disp_qj_busy && cdb_valid && (cdb_tag == disp_qj);
    assign byp_k = disp_qk_busy && cdb_valid && (cdb_tag == disp_qk);

    always_comb begin
        disp_entry         = '0;
        disp_entry.valid   = 1'b1;
        disp_entry.typ     = disp_type;
        disp_entry.details = disp_details;
        disp_entry.diff    = disp_diff;
        disp_entry.qj_busy = disp_qj_busy && !byp_j;
        disp_entry.qj      = disp_qj;
        disp_entry.vj      = byp_j ? cdb_value : disp_vj;
        disp_entry.qk_busy = disp_qk_busy && !byp_k;
        disp_entry.qk      = disp_qk;
        disp_entry.vk      = byp_k ? cdb_value : disp_vk;
        disp_entry.dest    = disp_dest;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                rs_q[i] <= '0;
            end
            alu_valid   <= 1'b0;
            alu_type    <= '0;
            alu_details <= '0;
            alu_diff    <= 1'b0;
            alu_r1      <= ZERO_WORD;
            alu_r2      <= ZERO_WORD;
            alu_tag     <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (rs_q[i].valid && cdb_valid) begin
                    if (rs_q[i].qj_busy && rs_q[i].qj == cdb_tag) begin
                        rs_q[i].qj_busy <= 1'b0;
                        rs_q[i].vj      <= cdb_value;
                    end
                    if (rs_q[i].qk_busy && rs_q[i].qk == cdb_tag) begin
                        rs_q[i].qk_busy <= 1'b0;
                        rs_q[i].vk      <= cdb_value;
                    end
                end
            end

            if (rdy_found) begin
                alu_valid           <= 1'b1;
                alu_type            <= rs_q[rdy_idx].typ;
                alu_details         <= rs_q[rdy_idx].details;
                alu_diff            <= rs_q[rdy_idx].diff;
                alu_r1              <= rs_q[rdy_idx].vj;
                alu_r2              <= rs_q[rdy_idx].vk;
                alu_tag             <= rs_q[rdy_idx].dest;
                rs_q[rdy_idx].valid <= 1'b0;
            end else begin
                alu_valid <= 1'b0;
            end

            // free_idx was empty at cycle start, so it never collides with issue
            if (disp_valid && free_found) begin
                rs_q[free_idx] <= disp_entry;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: vector table, directed
// multi-cycle sequences and a randomized run against a reference model.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        disp_valid;
    logic [1:0]  disp_type;
    logic [2:0]  disp_details;
    logic        disp_diff;
    logic [31:0] disp_vj, disp_vk;
    logic        disp_qj_busy, disp_qk_busy;
    logic [3:0]  disp_qj, disp_qk, disp_dest;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        full, alu_valid;
    logic [1:0]  alu_type;
    logic [2:0]  alu_details;
    logic        alu_diff;
    logic [31:0] alu_r1, alu_r2;
    logic [3:0]  alu_tag;

    int n_vec = 0;
    int n_bad = 0;

    alu_rs dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .clear_in(clear_in), .disp_valid(disp_valid),
        .disp_type(disp_type), .disp_details(disp_details),
        .disp_diff(disp_diff), .disp_vj(disp_vj),
        .disp_qj_busy(disp_qj_busy), .disp_qj(disp_qj),
        .disp_vk(disp_vk), .disp_qk_busy(disp_qk_busy),
        .disp_qk(disp_qk), .disp_dest(disp_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .full(full),
        .alu_valid(alu_valid), .alu_type(alu_type),
        .alu_details(alu_details), .alu_diff(alu_diff),
        .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_tag(alu_tag)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [1:0]  typ;
        logic [2:0]  det;
        logic        diff;
        logic [31:0] vj;
        logic        qjb;
        logic [3:0]  qj;
        logic [31:0] vk;
        logic        qkb;
        logic [3:0]  qk;
        logic [3:0]  dest;
        logic        cv;
        logic [3:0]  ct;
        logic [31:0] cval;
        logic [31:0] er1;
        logic [31:0] er2;
    } vec_t;

    vec_t tbl[6];

    // Reference model: slot contents as plain arrays
    bit          m_v[8];
    logic [1:0]  m_typ[8];
    logic [2:0]  m_det[8];
    logic        m_diff[8];
    bit          m_jb[8], m_kb[8];
    logic [3:0]  m_qj[8], m_qk[8], m_dest[8];
    logic [31:0] m_vj[8], m_vk[8];
    logic        e_valid;
    logic [1:0]  e_typ;
    logic [2:0]  e_det;
    logic        e_diff;
    logic [31:0] e_r1, e_r2;
    logic [3:0]  e_tag;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        disp_valid   = 1'b0;
        disp_qj_busy = 1'b0;
        disp_qk_busy = 1'b0;
        cdb_valid    = 1'b0;
        clear_in     = 1'b0;
    endtask

    task automatic drive_disp(input logic [1:0] typ, input logic [2:0] det,
                              input logic diff, input logic [31:0] vj,
                              input logic qjb, input logic [3:0] qj,
                              input logic [31:0] vk, input logic qkb,
                              input logic [3:0] qk, input logic [3:0] dest);
        disp_valid   = 1'b1;
        disp_type    = typ;
        disp_details = det;
        disp_diff    = diff;
        disp_vj      = vj;
        disp_qj_busy = qjb;
        disp_qj      = qj;
        disp_vk      = vk;
        disp_qk_busy = qkb;
        disp_qk      = qk;
        disp_dest    = dest;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_v[i] = 1'b0;
        e_valid = 1'b0; e_typ = '0; e_det = '0; e_diff = 1'b0;
        e_r1 = '0; e_r2 = '0; e_tag = '0;
    endtask

    // One clock edge of the station, evaluated from the current inputs
    task automatic model_step();
        int iss;
        int slot;
        iss  = -1;
        slot = -1;
        if (rst_in || clear_in) begin
            model_reset();
            return;
        end
        if (!rdy_in) return;
        for (int i = 0; i < 8; i++) begin
            if (iss < 0 && m_v[i] && !m_jb[i] && !m_kb[i]) iss = i;
            if (slot < 0 && !m_v[i]) slot = i;
        end
        e_valid = (iss >= 0);
        if (iss >= 0) begin
            e_typ = m_typ[iss]; e_det = m_det[iss]; e_diff = m_diff[iss];
            e_r1 = m_vj[iss]; e_r2 = m_vk[iss]; e_tag = m_dest[iss];
            m_v[iss] = 1'b0;
        end
        if (cdb_valid) begin
            for (int i = 0; i < 8; i++) begin
                if (m_jb[i] && m_qj[i] == cdb_tag) begin
                    m_jb[i] = 1'b0; m_vj[i] = cdb_value;
                end
                if (m_kb[i] && m_qk[i] == cdb_tag) begin
                    m_kb[i] = 1'b0; m_vk[i] = cdb_value;
                end
            end
        end
        if (disp_valid && slot >= 0) begin
            m_v[slot] = 1'b1;
            m_typ[slot] = disp_type; m_det[slot] = disp_details;
            m_diff[slot] = disp_diff; m_dest[slot] = disp_dest;
            m_qj[slot] = disp_qj; m_qk[slot] = disp_qk;
            m_vj[slot] = disp_vj; m_vk[slot] = disp_vk;
            m_jb[slot] = disp_qj_busy; m_kb[slot] = disp_qk_busy;
            if (disp_qj_busy && cdb_valid && cdb_tag == disp_qj) begin
                m_jb[slot] = 1'b0; m_vj[slot] = cdb_value;
            end
            if (disp_qk_busy && cdb_valid && cdb_tag == disp_qk) begin
                m_kb[slot] = 1'b0; m_vk[slot] = cdb_value;
            end
        end
    endtask

    function automatic bit model_full();
        for (int i = 0; i < 8; i++) if (!m_v[i]) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        tbl[0] = '{ALU_ALUOPI, F3_ADD, DIFF_NORM, 32'd5, 1'b0, 4'd0,
                   32'd7, 1'b0, 4'd0, 4'd3, 1'b0, 4'd0, 32'd0,
                   32'd5, 32'd7};
        tbl[1] = '{ALU_ALUOP, F3_ADD, DIFF_ALT, 32'h100, 1'b0, 4'd0,
                   32'h20, 1'b0, 4'd0, 4'd4, 1'b0, 4'd0, 32'd0,
                   32'h100, 32'h20};
        tbl[2] = '{ALU_ALUOP, F3_XOR, DIFF_NORM, 32'h11, 1'b0, 4'd0,
                   32'hAAAA, 1'b1, 4'd6, 4'd7, 1'b1, 4'd6, 32'd9,
                   32'h11, 32'd9};
        tbl[3] = '{ALU_CMP, F3_BLT, DIFF_NORM, 32'h1, 1'b1, 4'd5,
                   32'h2, 1'b1, 4'd5, 4'd8, 1'b1, 4'd5, 32'hDEADBEEF,
                   32'hDEADBEEF, 32'hDEADBEEF};
        tbl[4] = '{ALU_ALUOPI, F3_OR, DIFF_NORM, 32'h1234, 1'b0, 4'd2,
                   32'h5, 1'b0, 4'd0, 4'd9, 1'b1, 4'd2, 32'd99,
                   32'h1234, 32'h5};
        tbl[5] = '{ALU_ALUOP, F3_SR, DIFF_ALT, 32'h80000000, 1'b0, 4'd0,
                   32'd3, 1'b0, 4'd0, 4'd15, 1'b0, 4'd0, 32'd0,
                   32'h80000000, 32'd3};

        rst_in = 1'b1; rdy_in = 1'b1; idle_inputs();
        disp_type = '0; disp_details = '0; disp_diff = 1'b0;
        disp_vj = '0; disp_vk = '0; disp_qj = '0; disp_qk = '0;
        disp_dest = '0; cdb_tag = '0; cdb_value = '0;
        tick(); tick();
        rst_in = 1'b0;
        check("rst_valid", 128'(alu_valid), 128'(0));
        check("rst_full", 128'(full), 128'(0));
        check("rst_r1", 128'(alu_r1), 128'(0));

        for (int i = 0; i < 6; i++) begin
            drive_disp(tbl[i].typ, tbl[i].det, tbl[i].diff, tbl[i].vj,
                       tbl[i].qjb, tbl[i].qj, tbl[i].vk, tbl[i].qkb,
                       tbl[i].qk, tbl[i].dest);
            cdb_valid = tbl[i].cv;
            cdb_tag   = tbl[i].ct;
            cdb_value = tbl[i].cval;
            tick();
            idle_inputs();
            check("tbl_wait", 128'(alu_valid), 128'(0));
            tick();
            check("tbl_valid", 128'(alu_valid), 128'(1));
            check("tbl_issue",
                  128'({alu_type, alu_details, alu_diff, alu_r1, alu_r2, alu_tag}),
                  128'({tbl[i].typ, tbl[i].det, tbl[i].diff,
                        tbl[i].er1, tbl[i].er2, tbl[i].dest}));
        end

        drive_disp(ALU_ALUOP, F3_ADD, DIFF_NORM, 32'd0, 1'b1, 4'd2,
                   32'd1, 1'b0, 4'd0, 4'd5);
        tick();
        idle_inputs();
        check("wake_wait0", 128'(alu_valid), 128'(0));
        tick();
        check("wake_wait1", 128'(alu_valid), 128'(0));
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'h10;
        tick();
        idle_inputs();
        check("wake_edge", 128'(alu_valid), 128'(0));
        tick();
        check("wake_issue", 128'({alu_valid, alu_r1, alu_r2, alu_tag}),
              128'({1'b1, 32'h10, 32'd1, 4'd5}));

        for (int i = 0; i < 8; i++) begin
            drive_disp(ALU_ALUOP, F3_AND, DIFF_NORM, 32'd0, 1'b1, 4'd9,
                       32'(i), 1'b0, 4'd0, 4'(i));
            tick();
        end
        idle_inputs();
        check("fill_full", 128'(full), 128'(1));
        drive_disp(ALU_ALUOPI, F3_ADD, DIFF_NORM, 32'd1, 1'b0, 4'd0,
                   32'd1, 1'b0, 4'd0, 4'd15);
        tick();
        idle_inputs();
        check("drop_full", 128'(full), 128'(1));
        check("drop_valid", 128'(alu_valid), 128'(0));
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_value = 32'h77;
        tick();
        idle_inputs();
        check("wakeall_edge", 128'(alu_valid), 128'(0));
        for (int i = 0; i < 8; i++) begin
            tick();
            check("drain", 128'({alu_valid, alu_r1, alu_r2, alu_tag}),
                  128'({1'b1, 32'h77, 32'(i), 4'(i)}));
        end
        tick();
        check("drain_end", 128'({alu_valid, full}), 128'({1'b0, 1'b0}));

        for (int i = 0; i < 4; i++) begin
            drive_disp(ALU_ALUOP, F3_ADD, DIFF_NORM, 32'd0, 1'b1, 4'd11,
                       32'd1, 1'b0, 4'd0, 4'(i));
            tick();
        end
        drive_disp(ALU_ALUOPI, F3_ADD, DIFF_NORM, 32'd3, 1'b0, 4'd0,
                   32'd4, 1'b0, 4'd0, 4'd1);
        clear_in = 1'b1;
        tick();
        idle_inputs();
        check("clr_out", 128'({alu_valid, full, alu_r1, alu_tag}), 128'(0));
        cdb_valid = 1'b1; cdb_tag = 4'd11; cdb_value = 32'h5;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clr_quiet", 128'(alu_valid), 128'(0));
        end

        rdy_in = 1'b0;
        drive_disp(ALU_ALUOPI, F3_ADD, DIFF_NORM, 32'd8, 1'b0, 4'd0,
                   32'd8, 1'b0, 4'd0, 4'd6);
        tick();
        idle_inputs(); rdy_in = 1'b1;
        tick();
        check("frz_drop", 128'(alu_valid), 128'(0));
        drive_disp(ALU_ALUOPI, F3_ADD, DIFF_NORM, 32'd8, 1'b0, 4'd0,
                   32'd9, 1'b0, 4'd0, 4'd2);
        tick();
        idle_inputs(); rdy_in = 1'b0;
        tick();
        check("frz_hold0", 128'(alu_valid), 128'(0));
        rdy_in = 1'b1;
        tick();
        check("frz_issue", 128'({alu_valid, alu_tag, alu_r2}),
              128'({1'b1, 4'd2, 32'd9}));
        rdy_in = 1'b0;
        tick();
        check("frz_hold1", 128'(alu_valid), 128'(1));
        rdy_in = 1'b1;
        tick();
        check("frz_done", 128'(alu_valid), 128'(0));

        rst_in = 1'b1;
        model_step();
        tick();
        rst_in = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rdy_in       = ($urandom_range(0, 9) != 0);
            clear_in     = ($urandom_range(0, 49) == 0);
            disp_valid   = ($urandom_range(0, 9) < 6);
            disp_type    = 2'($urandom_range(1, 3));
            disp_details = 3'($urandom);
            disp_diff    = 1'($urandom);
            disp_vj      = $urandom;
            disp_vk      = $urandom;
            disp_qj_busy = 1'($urandom);
            disp_qk_busy = 1'($urandom);
            disp_qj      = 4'($urandom_range(0, 7));
            disp_qk      = 4'($urandom_range(0, 7));
            disp_dest    = 4'($urandom);
            cdb_valid    = ($urandom_range(0, 9) < 6);
            cdb_tag      = 4'($urandom_range(0, 7));
            cdb_value    = $urandom;
            model_step();
            tick();
            check("rnd_full", 128'(full), 128'(model_full()));
            check("rnd_valid", 128'(alu_valid), 128'(e_valid));
            check("rnd_data",
                  128'({alu_type, alu_details, alu_diff, alu_r1, alu_r2, alu_tag}),
                  128'({e_typ, e_det, e_diff, e_r1, e_r2, e_tag}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
